// File: rtl/ip_unmask_serial_if.sv
// Handshake bundle for the serial inner-product unmasker: operands in, unmasked byte out.
interface ip_unmask_serial_if #(parameter int V = 8);
    logic           in_valid;
    logic           in_ready;
    logic [V*8-1:0] L;
    logic [V*8-1:0] R;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     S;

    modport master (output in_valid, L, R, out_ready, input in_ready, out_valid, S);
    modport slave  (input in_valid, L, R, out_ready, output in_ready, out_valid, S);
endinterface

// File: rtl/ip_unmask_serial.sv
// Serial inner-product unmasking: S = R_0 ^ sum_{i>=1} L_i*R_i over GF(2^8),
// one shared multiplier stepping through the shares one per cycle.
module gmul8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);
    logic [7:0] w_a;

    // Shift-and-add with on-the-fly reduction by x^8+x^4+x^3+x+1
    always_comb begin
        o_p = 8'h00;
        w_a = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) o_p = o_p ^ w_a;
            w_a = {w_a[6:0], 1'b0} ^ (w_a[7] ? 8'h1B : 8'h00);
        end
    end
endmodule

module ip_unmask_serial #(
    parameter int V = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ip_unmask_serial_if.slave bus
);
    localparam int IW = $clog2(V) + 1;
    localparam int W  = V * 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_lreg, r_rreg;
    logic [7:0]      r_acc;
    logic [IW-1:0]   r_idx;
    logic [7:0]      w_la, w_ra, w_prod;
    logic            w_last;

    always_comb begin
        w_la = 8'h00;
        w_ra = 8'h00;
        for (int i = 0; i < V; i++) begin
            if (r_idx == IW'(i)) begin
                w_la = r_lreg[i*8 +: 8];
                w_ra = r_rreg[i*8 +: 8];
            end
        end
    end

    gmul8 u_gmul (.i_a(w_la), .i_b(w_ra), .o_p(w_prod));

    assign w_last = (r_idx == IW'(V - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Outputs decode state only; S is gated so shares never reach the bus while idle/busy
    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.S         = 8'h00;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_next = (V > 1) ? BUSY : DONE;
            end
            BUSY: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.S         = r_acc;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lreg <= '0;
            r_rreg <= '0;
            r_acc  <= 8'h00;
            r_idx  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_lreg <= bus.L;
                    r_rreg <= bus.R;
                    r_acc  <= bus.R[7:0];
                    r_idx  <= IW'(1);
                end
                BUSY: begin
                    r_acc <= r_acc ^ w_prod;
                    r_idx <= r_idx + IW'(1);
                end
                DONE: if (bus.out_ready) begin
                    r_lreg <= '0;
                    r_rreg <= '0;
                    r_acc  <= 8'h00;
                    r_idx  <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ip_unmask_serial.sv
// Directed bench for ip_unmask_serial at v = 1, 2, 4 and 8 shares.
module tb_ip_unmask_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ip_unmask_serial_if #(.V(1)) b1();
    ip_unmask_serial_if #(.V(2)) b2();
    ip_unmask_serial_if #(.V(4)) b4();
    ip_unmask_serial_if #(.V(8)) b8();

    ip_unmask_serial #(.V(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    ip_unmask_serial #(.V(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    ip_unmask_serial #(.V(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    ip_unmask_serial #(.V(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    // Reference multiply: full carry-less product, then polynomial reduction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
        return p[7:0];
    endfunction

    // Accept one operand set with out_ready high; return S and edges from accept to out_valid
    `define DEF_RUN(TNAME, BUS, NV) \
    task automatic TNAME(input logic [NV*8-1:0] l, input logic [NV*8-1:0] r, output logic [7:0] s, output int lat); \
        @(negedge clk); BUS.L = l; BUS.R = r; BUS.in_valid = 1'b1; BUS.out_ready = 1'b1; \
        @(negedge clk); BUS.in_valid = 1'b0; lat = 1; \
        while (!BUS.out_valid && lat < 40) begin @(negedge clk); lat++; end \
        s = BUS.S; \
        @(negedge clk); \
    endtask

    `DEF_RUN(run1, b1, 1)
    `DEF_RUN(run2, b2, 2)
    `DEF_RUN(run4, b4, 4)
    `DEF_RUN(run8, b8, 8)

    task automatic test_reset;
        logic [3:0] ir, ov;
        ir = {b8.in_ready, b4.in_ready, b2.in_ready, b1.in_ready};
        ov = {b8.out_valid, b4.out_valid, b2.out_valid, b1.out_valid};
        checks++; if (ir !== 4'hF) begin errors++; $display("FAIL reset_in_ready: got %b expected 1111", ir); end
        checks++; if (ov !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0000", ov); end
        checks++; if (b8.S !== 8'h00) begin errors++; $display("FAIL reset_S: got %h expected 00", b8.S); end
        checks++; if (dut8.r_acc !== 8'h00 || dut8.r_lreg !== 64'h0) begin
            errors++; $display("FAIL reset_regs: acc %h lreg %h expected 0", dut8.r_acc, dut8.r_lreg); end
    endtask

    task automatic test_v2;
        logic [7:0] s; int lat;
        run2(16'h8300, 16'h5700, s, lat);
        checks++; if (s !== 8'hC1) begin errors++; $display("FAIL v2_mul: got %h expected c1", s); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL v2_latency: got %0d expected 2", lat); end
        run2(16'h8300, 16'h57C1, s, lat);
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL v2_cancel: got %h expected 00", s); end
    endtask

    task automatic test_roundtrip;
        logic [63:0] l, r; logic [7:0] s, acc, sec; int lat; int bad;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            sec = (n == 0) ? 8'h3A : 8'($urandom);
            l = {$urandom, $urandom};
            r = {$urandom, $urandom};
            acc = 8'h00;
            for (int i = 1; i < 8; i++) acc = acc ^ gf_mul(l[i*8 +: 8], r[i*8 +: 8]);
            r[7:0] = sec ^ acc;
            run8(l, r, s, lat);
            checks++;
            if (s !== sec) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL roundtrip[%0d]: got %h expected %h", n, s, sec);
            end
            if (n == 0) begin
                checks++; if (lat !== 8) begin errors++; $display("FAIL v8_latency: got %0d expected 8", lat); end
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk); b8.L = 64'h8300; b8.R = 64'h5700; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
        @(negedge clk); b8.in_valid = 1'b0; lat = 1;
        while (!b8.out_valid && lat < 40) begin @(negedge clk); lat++; end
        for (int k = 0; k < 5; k++) begin
            checks++; if (b8.out_valid !== 1'b1 || b8.S !== 8'hC1 || b8.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: ov %b S %h ir %b expected 1 c1 0", k, b8.out_valid, b8.S, b8.in_ready); end
            b8.in_valid = (k == 2);
            b8.L = 64'hDEAD_BEEF_0123_4567; b8.R = 64'h0F0F_1234_5678_9ABC;
            @(negedge clk);
        end
        b8.in_valid = 1'b0;
        checks++; if (b8.S !== 8'hC1) begin errors++; $display("FAIL bp_release_S: got %h expected c1", b8.S); end
        b8.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (b8.out_valid !== 1'b0 || b8.S !== 8'h00 || b8.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_after: ov %b S %h ir %b expected 0 00 1", b8.out_valid, b8.S, b8.in_ready); end
        @(negedge clk);
        checks++; if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_no_phantom: ov %b ir %b expected 0 1", b8.out_valid, b8.in_ready); end
    endtask

    task automatic test_reset_busy;
        logic [7:0] s; int lat;
        @(negedge clk); b8.L = 64'hFFFF_FFFF_FFFF_8300; b8.R = 64'h1111_1111_1111_5733; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
        @(negedge clk); b8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.S !== 8'h00) begin
            errors++; $display("FAIL rst_busy_out: ir %b ov %b S %h expected 1 0 00", b8.in_ready, b8.out_valid, b8.S); end
        checks++; if (dut8.r_acc !== 8'h00 || dut8.r_idx !== '0) begin
            errors++; $display("FAIL rst_busy_regs: acc %h idx %0d expected 0", dut8.r_acc, dut8.r_idx); end
        @(negedge clk); rst_n = 1'b1;
        run8(64'h8300, 64'h5711, s, lat);
        checks++; if (s !== 8'hD0) begin errors++; $display("FAIL rst_busy_fresh: got %h expected d0", s); end
    endtask

    task automatic test_zero_l;
        logic [7:0] s; int lat; logic [31:0] r;
        r = $urandom;
        r[7:0] = 8'h5C;
        run4(32'h0, r, s, lat);
        checks++; if (s !== 8'h5C) begin errors++; $display("FAIL zero_l_v4: got %h expected 5c", s); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL v4_latency: got %0d expected 4", lat); end
        run1(8'h00, 8'hA7, s, lat);
        checks++; if (s !== 8'hA7) begin errors++; $display("FAIL v1_pass: got %h expected a7", s); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL v1_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_clear;
        logic [7:0] s; int lat;
        run8(64'h0102_0304_0506_0700, 64'h0807_0605_0403_0299, s, lat);
        checks++; if (dut8.r_lreg !== 64'h0 || dut8.r_rreg !== 64'h0 || dut8.r_acc !== 8'h00) begin
            errors++; $display("FAIL clear_regs: lreg %h rreg %h acc %h expected 0", dut8.r_lreg, dut8.r_rreg, dut8.r_acc); end
        checks++; if (b8.S !== 8'h00 || b8.out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_S: S %h ov %b expected 00 0", b8.S, b8.out_valid); end
    endtask

    initial begin
        b1.in_valid = 0; b1.out_ready = 0; b1.L = '0; b1.R = '0;
        b2.in_valid = 0; b2.out_ready = 0; b2.L = '0; b2.R = '0;
        b4.in_valid = 0; b4.out_ready = 0; b4.L = '0; b4.R = '0;
        b8.in_valid = 0; b8.out_ready = 0; b8.L = '0; b8.R = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_v2;
        test_roundtrip;
        test_backpressure;
        test_reset_busy;
        test_zero_l;
        test_clear;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
